// File: rtl/vga_pattern_gen.sv
// Purpose : VGA test-pattern source; maps the active-area pixel coordinate to a registered RGB word.
// Latency : pix_data is one vga_clk cycle behind (pix_x, pix_y); frame-end state updates one cycle after fe.
// Backpr. : none; free-running pixel stream that follows the timing block every cycle.
//
// Ports:
//   vga_clk      pixel clock, all state on its rising edge
//   sys_rst      synchronous active-high reset
//   pix_x/pix_y  active-area coordinate from the timing block
//   mode_in      requested pattern (0 bars, 1 scroll, 2 checker, 3 grey ramp), sampled only at frame end
//   pix_data     registered pixel colour, R in MSBs, B in LSBs
//   mode_active  pattern currently displayed
//   frame_cnt    completed-frame count, wraps at 2^16
module vga_pattern_gen #(
    parameter int H_VALID     = 640,
    parameter int V_VALID     = 480,
    parameter int COORD_W     = 10,
    parameter int RGB_W       = 12,
    parameter int N_BARS      = 8,
    parameter int SCROLL_STEP = 4,
    parameter int CHECK_LOG2  = 5,
    parameter int BLINK_LOG2  = 5
) (
    input  logic               vga_clk,
    input  logic               sys_rst,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [1:0]         mode_in,
    output logic [RGB_W-1:0]   pix_data,
    output logic [1:0]         mode_active,
    output logic [15:0]        frame_cnt
);

    localparam int C     = RGB_W / 3;
    localparam int BAR_W = H_VALID / N_BARS;
    localparam int XW    = COORD_W + 1;   // one extra bit to hold coordinate + offset sums

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_RAMP   = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RGB_W-1:0]   pix_q,       pix_d;
    mode_e              mode_q,      mode_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [COORD_W-1:0] scroll_q,    scroll_d;
    logic               match_q,     match_d;

    logic               fe;
    logic               in_area;
    logic [XW-1:0]      x_sum;
    logic [XW-1:0]      x_eff;
    logic [XW-1:0]      s_sum;
    logic [XW-1:0]      s_wrap;
    logic [3:0]         bar_k;
    logic [C-1:0]       grey;
    logic               chk_bit;

    // ------------------------------------------------------------------
    // Colour helpers
    // ------------------------------------------------------------------
    // Eight-entry bar palette; bars beyond the eighth reuse it (index mod 8).
    function automatic logic [RGB_W-1:0] palette(input logic [2:0] idx);
        logic [C-1:0] f;
        logic [C-1:0] h;
        logic [C-1:0] z;
        logic [RGB_W-1:0] rgb;
        f = '1;
        z = '0;
        h = '0;
        h[C-1] = 1'b1;
        case (idx)
            3'd0:    rgb = {f, z, z};   // red
            3'd1:    rgb = {f, h, z};   // orange
            3'd2:    rgb = {f, f, z};   // yellow
            3'd3:    rgb = {z, f, z};   // green
            3'd4:    rgb = {z, f, f};   // cyan
            3'd5:    rgb = {z, z, f};   // blue
            3'd6:    rgb = {f, z, f};   // purple
            default: rgb = {f, f, f};   // white
        endcase
        return rgb;
    endfunction

    // Bar number from a horizontal position. Built as a ladder of constant
    // compares against the bar edges instead of a divider; positions past the
    // last full bar fall into the last bar because the ladder stops there.
    function automatic logic [3:0] bar_index(input logic [XW-1:0] x);
        int         xi;
        logic [3:0] k;
        xi = int'(x);
        k  = '0;
        for (int j = 1; j < N_BARS; j++) begin
            if (xi >= j * BAR_W) begin
                k = 4'(j);
            end
        end
        return k;
    endfunction

    // Grey level floor(x * 2^C / H_VALID), again as a compare ladder. The
    // ladder tops out at 2^C-1, which gives the saturation for free.
    function automatic logic [C-1:0] ramp_level(input logic [COORD_W-1:0] x);
        int           xi;
        logic [C-1:0] g;
        xi = int'(x);
        g  = '0;
        for (int j = 1; j < (1 << C); j++) begin
            if (xi * (1 << C) >= j * H_VALID) begin
                g = C'(j);
            end
        end
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Frame-end detection and frame-boundary state
    // ------------------------------------------------------------------
    // fe fires on the rising edge of the last-pixel match, so a coordinate
    // held on the last pixel counts as a single frame end.
    always_comb begin
        match_d = (pix_x == COORD_W'(H_VALID - 1)) && (pix_y == COORD_W'(V_VALID - 1));
        fe      = match_d && !match_q;
    end

    // Next scroll offset, kept in 0..H_VALID-1 with a single compare-and-subtract.
    always_comb begin
        s_sum  = {1'b0, scroll_q} + XW'(SCROLL_STEP);
        s_wrap = (s_sum >= XW'(H_VALID)) ? (s_sum - XW'(H_VALID)) : s_sum;
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        scroll_d    = scroll_q;
        if (fe) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            // A pending mode change takes priority over scrolling and restarts
            // the scroll from zero.
            if (mode_in != mode_q) begin
                mode_d   = mode_e'(mode_in);
                scroll_d = '0;
            end else if (mode_q == MODE_SCROLL) begin
                scroll_d = s_wrap[COORD_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    // All pattern terms use the registered mode/offset/count, so the frame-end
    // pixel itself is still drawn with the old frame's settings.
    always_comb begin
        in_area = (pix_x < COORD_W'(H_VALID)) && (pix_y < COORD_W'(V_VALID));

        x_sum = {1'b0, pix_x} + {1'b0, scroll_q};
        x_eff = (x_sum >= XW'(H_VALID)) ? (x_sum - XW'(H_VALID)) : x_sum;

        chk_bit = pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2] ^ frame_cnt_q[BLINK_LOG2];
        grey    = ramp_level(pix_x);

        bar_k = '0;
        pix_d = '0;
        if (in_area) begin
            case (mode_q)
                MODE_BARS: begin
                    bar_k = bar_index({1'b0, pix_x});
                    pix_d = palette(bar_k[2:0]);
                end
                MODE_SCROLL: begin
                    bar_k = bar_index(x_eff);
                    pix_d = palette(bar_k[2:0]);
                end
                MODE_CHECK: begin
                    pix_d = chk_bit ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
                end
                default: begin
                    pix_d = {grey, grey, grey};
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pix_q       <= '0;
            mode_q      <= MODE_BARS;
            frame_cnt_q <= '0;
            scroll_q    <= '0;
            match_q     <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            scroll_q    <= scroll_d;
            match_q     <= match_d;
        end
    end

    assign pix_data    = pix_q;
    assign mode_active = mode_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Purpose : self-checking bench for vga_pattern_gen against a behavioural frame/pixel model.
// Latency : model predicts pix_data one cycle after the coordinate is driven.
// Backpr. : none; the bench drives one coordinate per clock.
module tb_vga_pattern_gen;

    localparam int H  = 640;
    localparam int V  = 480;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [1:0]  mode_in;
    logic [11:0] pix_data;
    logic [1:0]  mode_active;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int m_mode   = 0;
    int m_scroll = 0;
    int m_fcnt   = 0;
    bit m_last   = 1'b0;   // previous cycle was on the last pixel

    logic [11:0] pal [8] = '{12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                             12'h0FF, 12'h00F, 12'hF0F, 12'hFFF};

    vga_pattern_gen dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .mode_in     (mode_in),
        .pix_data    (pix_data),
        .mode_active (mode_active),
        .frame_cnt   (frame_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int x, input int y, input int mode,
                                            input int scroll, input int fcnt);
        int k;
        int g;
        int b;
        if (x >= H || y >= V) return 12'h000;
        case (mode)
            0, 1: begin
                k = ((mode == 1) ? ((x + scroll) % H) : x) / (H / 8);
                if (k > 7) k = 7;
                return pal[k % 8];
            end
            2: begin
                b = ((x / 32) ^ (y / 32) ^ (fcnt / 32)) & 1;
                return (b != 0) ? 12'hFFF : 12'h000;
            end
            default: begin
                g = (x * 16) / H;
                if (g > 15) g = 15;
                return 12'((g << 8) | (g << 4) | g);
            end
        endcase
    endfunction

    // Drive one coordinate, advance the model, clock, then compare all outputs.
    task automatic step(input int x, input int y, input int m, input bit r);
        logic [11:0] exp_pix;
        bit          is_last;
        pix_x   = 10'(x);
        pix_y   = 10'(y);
        mode_in = 2'(m);
        sys_rst = r;
        if (r) begin
            exp_pix  = 12'h000;
            m_mode   = 0;
            m_scroll = 0;
            m_fcnt   = 0;
            m_last   = 1'b0;
        end else begin
            exp_pix = ref_pix(x, y, m_mode, m_scroll, m_fcnt);
            is_last = (x == H - 1) && (y == V - 1);
            if (is_last && !m_last) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                if (m != m_mode) begin
                    m_mode   = m;
                    m_scroll = 0;
                end else if (m_mode == 1) begin
                    m_scroll = (m_scroll + 4) % H;
                end
            end
            m_last = is_last;
        end
        @(posedge vga_clk);
        #1;
        check("pix", 32'(pix_data), 32'(exp_pix));
        check("mode", 32'(mode_active), 32'(m_mode));
        check("fcnt", 32'(frame_cnt), 32'(m_fcnt));
    endtask

    task automatic frame_end(input int m);
        step(H - 1, V - 1, m, 1'b0);
        step(0, 0, m, 1'b0);
    endtask

    initial begin
        int cur_m;
        int r;
        sys_rst = 1'b1;
        pix_x   = '0;
        pix_y   = '0;
        mode_in = '0;

        // reset state
        step(0, 0, 0, 1'b1);
        check("rst_pix", 32'(pix_data), 32'h0);
        check("rst_mode", 32'(mode_active), 32'h0);
        check("rst_fcnt", 32'(frame_cnt), 32'h0);

        // static bars, including bar edge and out-of-area column
        step(79, 0, 0, 1'b0);  check("bar79", 32'(pix_data), 32'hF00);
        step(80, 0, 0, 1'b0);  check("bar80", 32'(pix_data), 32'hF80);
        step(639, 0, 0, 1'b0); check("bar639", 32'(pix_data), 32'hFFF);
        step(640, 0, 0, 1'b0); check("bar640", 32'(pix_data), 32'h000);
        step(10, 480, 0, 1'b0); check("row480", 32'(pix_data), 32'h000);

        // scroll: switch frame, then three advances to offset 12
        frame_end(1);
        check("scr_mode", 32'(mode_active), 32'h1);
        repeat (3) frame_end(1);
        step(68, 5, 1, 1'b0);  check("scr12_x68", 32'(pix_data), 32'hF80);
        repeat (156) frame_end(1);   // offset 636
        step(4, 0, 1, 1'b0);   check("scr636_x4", 32'(pix_data), 32'hF00);
        step(3, 0, 1, 1'b0);   check("scr636_x3", 32'(pix_data), 32'hFFF);
        frame_end(1);                // wraps to 0
        step(0, 0, 1, 1'b0);   check("scrwrap_x0", 32'(pix_data), 32'hF00);
        step(80, 0, 1, 1'b0);  check("scrwrap_x80", 32'(pix_data), 32'hF80);

        // checker blink
        step(0, 0, 2, 1'b1);
        frame_end(2);
        step(32, 0, 2, 1'b0);  check("chk_32_0", 32'(pix_data), 32'hFFF);
        step(32, 32, 2, 1'b0); check("chk_32_32", 32'(pix_data), 32'h000);
        repeat (32) frame_end(2);
        step(32, 0, 2, 1'b0);  check("chk_blink", 32'(pix_data), 32'h000);

        // grey ramp
        frame_end(3);
        step(0, 0, 3, 1'b0);   check("ramp0", 32'(pix_data), 32'h000);
        step(320, 0, 3, 1'b0); check("ramp320", 32'(pix_data), 32'h888);
        step(639, 0, 3, 1'b0); check("ramp639", 32'(pix_data), 32'hFFF);

        // mode request only honoured at frame end; held last pixel gives one fe
        step(0, 0, 0, 1'b1);
        step(100, 100, 3, 1'b0); check("sw_still_bars", 32'(pix_data), 32'hF80);
        step(H - 1, V - 1, 3, 1'b0);
        check("sw_mode", 32'(mode_active), 32'h3);
        check("sw_fcnt1", 32'(frame_cnt), 32'h1);
        repeat (4) step(H - 1, V - 1, 3, 1'b0);
        check("sw_fcnt_hold", 32'(frame_cnt), 32'h1);

        // reset in the middle of a scrolling frame
        step(0, 0, 0, 1'b1);
        repeat (11) frame_end(1);    // offset 40, count 11
        step(40, 0, 1, 1'b0);  check("mid_scr40", 32'(pix_data), 32'hF80);
        step(200, 10, 1, 1'b1);
        check("mid_rst_pix", 32'(pix_data), 32'h0);
        check("mid_rst_mode", 32'(mode_active), 32'h0);
        check("mid_rst_fcnt", 32'(frame_cnt), 32'h0);
        step(79, 0, 1, 1'b0);  check("mid_bars", 32'(pix_data), 32'hF00);

        // randomized traffic against the model
        cur_m = 0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1)
                step(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), cur_m, 1'b1);
            else if (r < 15)
                step(H - 1, V - 1, cur_m, 1'b0);
            else
                step(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), cur_m, 1'b0);
            if ($urandom_range(0, 49) == 0) cur_m = int'($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
